btn_event_encoder: RTL and testbench

//  Consumes the debounced, active-high button levels and turns them into a stream of

---
 rtl/btn_event_encoder.sv | 224 ++++++++++++++++++++++
 tb/tb_btn_event_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/btn_event_encoder.sv
// btn_event_encoder
//   Turns debounced, active-high button levels into discrete events
//   (PRESS, LONG, RELEASE and, optionally, REPEAT). Each event is held in a
//   per-button pending bit, then moved into a small first-word-fall-through
//   FIFO by a fixed-priority arbiter. The FIFO drains over valid/ready.
//
//   Build option: define BTN_AUTOREPEAT_EN to build the REPEAT generator.
//   Without it, type 2'b11 is never produced and REPEAT_CYCLES is unused.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   btn_in         in   [WIDTH-1:0] debounced button levels, 1 = pressed
//   event_valid    out  FIFO head holds an event
//   event_ready    in   head is consumed when valid & ready at a clock edge
//   event_data     out  [IDX_W+1:0] {type[1:0], index}; 00 PRESS, 01 LONG,
//                       10 RELEASE, 11 REPEAT
//   fifo_count     out  [FIFO_AW:0] queued events, 0..FIFO_DEPTH
//   overrun        out  sticky: an event was coalesced into a pending one
//   clear_overrun  in   synchronous clear of overrun (a new overrun wins)
module btn_event_encoder #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned CNT_WIDTH     = 25,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned FIFO_AW       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   btn_in,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [IDX_W+1:0]   event_data,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overrun,
  input  logic               clear_overrun
);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_LONG    = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_type_t;

  localparam logic [CNT_WIDTH-1:0] LONG_C  = CNT_WIDTH'(LONG_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LONG_M1 = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [FIFO_AW:0]     DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0]     r_btn_q;
  logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]     r_pend_press, r_pend_long, r_pend_release;
  logic [WIDTH-1:0]     w_rise, w_fall, w_long_det;
  logic [WIDTH-1:0]     w_gnt_press, w_gnt_long, w_gnt_release;
  logic                 w_ovr_set;

  logic [IDX_W+1:0]     r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [FIFO_AW:0]     r_count, w_count_next, w_count_after_pop;
  logic [IDX_W+1:0]     r_data, w_push_data, w_data_next;
  logic                 r_valid, r_overrun, w_push, w_pop;

  assign w_rise = btn_in & ~r_btn_q;
  assign w_fall = ~btn_in & r_btn_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_M1 = CNT_WIDTH'(REPEAT_CYCLES - 1);

  logic [WIDTH-1:0] r_rep_mode, r_pend_repeat, w_rep_det, w_gnt_repeat;

  // The counter is reused: it counts to LONG, then restarts and cycles
  // through REPEAT periods while the button stays held.
  always_comb begin
    w_long_det = '0;
    w_rep_det  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_long_det[i] = btn_in[i] & ~w_rise[i] & ~r_rep_mode[i] & (r_cnt[i] == LONG_M1);
      w_rep_det[i]  = btn_in[i] & ~w_rise[i] &  r_rep_mode[i] & (r_cnt[i] == REP_M1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_mode    <= '0;
      r_pend_repeat <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_pend_repeat <= (r_pend_repeat & ~w_gnt_repeat) | w_rep_det;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!btn_in[i] || w_rise[i]) begin
          r_cnt[i]      <= '0;
          r_rep_mode[i] <= 1'b0;
        end else if (w_long_det[i]) begin
          r_cnt[i]      <= '0;
          r_rep_mode[i] <= 1'b1;
        end else if (w_rep_det[i]) begin
          r_cnt[i]      <= '0;
        end else begin
          r_cnt[i]      <= r_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Counter saturates at LONG, so the LONG-1 -> LONG step happens once per press.
  always_comb begin
    w_long_det = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      w_long_det[i] = btn_in[i] & ~w_rise[i] & (r_cnt[i] == LONG_M1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!btn_in[i] || w_rise[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] != LONG_C) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
`endif

  // Arbiter: lowest button first; within a button PRESS > LONG > REPEAT > RELEASE.
  always_comb begin
    w_push        = 1'b0;
    w_push_data   = '0;
    w_gnt_press   = '0;
    w_gnt_long    = '0;
    w_gnt_release = '0;
`ifdef BTN_AUTOREPEAT_EN
    w_gnt_repeat  = '0;
`endif
    if (r_count != DEPTH_C) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!w_push) begin
          if (r_pend_press[i]) begin
            w_push = 1'b1; w_gnt_press[i] = 1'b1;
            w_push_data = {EV_PRESS, IDX_W'(i)};
          end else if (r_pend_long[i]) begin
            w_push = 1'b1; w_gnt_long[i] = 1'b1;
            w_push_data = {EV_LONG, IDX_W'(i)};
`ifdef BTN_AUTOREPEAT_EN
          end else if (r_pend_repeat[i]) begin
            w_push = 1'b1; w_gnt_repeat[i] = 1'b1;
            w_push_data = {EV_REPEAT, IDX_W'(i)};
`endif
          end else if (r_pend_release[i]) begin
            w_push = 1'b1; w_gnt_release[i] = 1'b1;
            w_push_data = {EV_RELEASE, IDX_W'(i)};
          end
        end
      end
    end
  end

  // A set landing on a bit that is being granted this cycle is not a loss:
  // the old event leaves and the new one stays pending, so no overrun.
  always_comb begin
    w_ovr_set = |((w_rise     & r_pend_press   & ~w_gnt_press)   |
                  (w_long_det & r_pend_long    & ~w_gnt_long)    |
                  (w_fall     & r_pend_release & ~w_gnt_release));
`ifdef BTN_AUTOREPEAT_EN
    w_ovr_set = w_ovr_set | (|(w_rep_det & r_pend_repeat & ~w_gnt_repeat));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q        <= '0;
      r_pend_press   <= '0;
      r_pend_long    <= '0;
      r_pend_release <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_btn_q        <= btn_in;
      r_pend_press   <= (r_pend_press   & ~w_gnt_press)   | w_rise;
      r_pend_long    <= (r_pend_long    & ~w_gnt_long)    | w_long_det;
      r_pend_release <= (r_pend_release & ~w_gnt_release) | w_fall;
      r_overrun      <= (r_overrun & ~clear_overrun) | w_ovr_set;
    end
  end

  // FIFO with registered head: the next head is either the bypassed push
  // (queue would otherwise be empty) or the entry after the current head.
  assign w_pop             = r_valid & event_ready;
  assign w_rd_next         = r_rd_ptr + FIFO_AW'(w_pop);
  assign w_count_after_pop = r_count - (FIFO_AW+1)'(w_pop);

  always_comb begin
    w_count_next = w_count_after_pop + (FIFO_AW+1)'(w_push);
    w_data_next  = r_data;
    if (w_count_after_pop != '0) w_data_next = r_mem[w_rd_next];
    else if (w_push)             w_data_next = w_push_data;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + FIFO_AW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_data   <= w_data_next;
      r_valid  <= (w_count_next != '0);
    end
  end

  assign event_valid = r_valid;
  assign event_data  = r_data;
  assign fifo_count  = r_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_btn_event_encoder.sv
module tb_btn_event_encoder;
  localparam int unsigned WIDTH   = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned FIFO_AW = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   btn_in;
  logic               event_valid;
  logic               event_ready;
  logic [IDX_W+1:0]   event_data;
  logic [FIFO_AW:0]   fifo_count;
  logic               overrun;
  logic               clear_overrun;

  int n_cmp = 0;
  int n_err = 0;

  btn_event_encoder #(
    .WIDTH(5), .IDX_W(3), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
    .CNT_WIDTH(25), .FIFO_DEPTH(8), .FIFO_AW(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_data(event_data), .fifo_count(fifo_count),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a head event with ready held high, check it, consume it.
  task automatic expect_ev(input string tag, input logic [4:0] exp);
    int unsigned k = 0;
    while (!event_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, {31'd0, event_valid}, 32'd1);
    chk(tag, {27'd0, event_data}, {27'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_in = '0; event_ready = 1'b0; clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, event_valid}, 32'd0);
    chk("rst_data",  {27'd0, event_data},  32'd0);
    chk("rst_count", {28'd0, fifo_count},  32'd0);
    chk("rst_ovr",   {31'd0, overrun},     32'd0);

    // 1: button held through reset -> PRESS idx2 two clocks after release
    btn_in = 5'b00100; reset = 1'b0;
    @(negedge clk);
    chk("t1_valid_e0", {31'd0, event_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_e1", {31'd0, event_valid}, 32'd1);
    chk("t1_data",  {27'd0, event_data}, 32'h02);
    chk("t1_count", {28'd0, fifo_count}, 32'd1);
    event_ready = 1'b1;
    @(negedge clk);
    chk("t1_popped", {28'd0, fifo_count}, 32'd0);
    btn_in = '0;
    expect_ev("t1_rel2", 5'b10010);
    chk("t1_count_end", {28'd0, fifo_count}, 32'd0);

    // 2: short tap -> PRESS, RELEASE, no LONG
    event_ready = 1'b0;
    btn_in = 5'b00001;
    repeat (5) @(negedge clk);
    btn_in = '0;
    repeat (25) @(negedge clk);
    chk("t2_count", {28'd0, fifo_count}, 32'd2);
    event_ready = 1'b1;
    expect_ev("t2_press0", 5'b00000);
    expect_ev("t2_rel0",   5'b10000);
    repeat (3) @(negedge clk);
    chk("t2_count_end", {28'd0, fifo_count}, 32'd0);
    chk("t2_valid_end", {31'd0, event_valid}, 32'd0);

    // 3: long hold -> LONG pushed 20 cycles after PRESS
    event_ready = 1'b0;
    btn_in = 5'b00010;
    repeat (21) @(negedge clk);
    chk("t3_before_long", {28'd0, fifo_count}, 32'd1);
    @(negedge clk);
    chk("t3_long_in", {28'd0, fifo_count}, 32'd2);
    repeat (8) @(negedge clk);
    btn_in = '0;
    repeat (4) @(negedge clk);
`ifdef BTN_AUTOREPEAT_EN
    chk("t3_count", {28'd0, fifo_count}, 32'd4);
`else
    chk("t3_count", {28'd0, fifo_count}, 32'd3);
`endif
    event_ready = 1'b1;
    expect_ev("t3_press1", 5'b00001);
    expect_ev("t3_long1",  5'b01001);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev("t3_rep1",   5'b11001);
`endif
    expect_ev("t3_rel1",   5'b10001);
    chk("t3_count_end", {28'd0, fifo_count}, 32'd0);

    // 4: simultaneous rise on btn0 and btn4 -> idx0 pushed first
    event_ready = 1'b0;
    btn_in = 5'b10001;
    @(negedge clk);
    chk("t4_count_e0", {28'd0, fifo_count}, 32'd0);
    @(negedge clk);
    chk("t4_count_e1", {28'd0, fifo_count}, 32'd1);
    chk("t4_head",     {27'd0, event_data}, 32'h00);
    @(negedge clk);
    chk("t4_count_e2", {28'd0, fifo_count}, 32'd2);
    btn_in = '0;
    repeat (4) @(negedge clk);
    chk("t4_count", {28'd0, fifo_count}, 32'd4);
    event_ready = 1'b1;
    expect_ev("t4_press0", 5'b00000);
    expect_ev("t4_press4", 5'b00100);
    expect_ev("t4_rel0",   5'b10000);
    expect_ev("t4_rel4",   5'b10100);

    // 5: FIFO saturates at 8, remaining events wait in pending bits
    event_ready = 1'b0;
    btn_in = 5'b11111;
    repeat (8) @(negedge clk);
    btn_in = '0;
    repeat (10) @(negedge clk);
    chk("t5_full", {28'd0, fifo_count}, 32'd8);
    chk("t5_valid", {31'd0, event_valid}, 32'd1);
    event_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_ev("t5_press", {2'b00, 3'(i)});
    for (int i = 0; i < 5; i++) expect_ev("t5_rel",   {2'b10, 3'(i)});
    chk("t5_count_end", {28'd0, fifo_count}, 32'd0);

    // 6: coalescing while full sets overrun; one PRESS idx3 survives
    event_ready = 1'b0;
    btn_in = 5'b10111;
    repeat (6) @(negedge clk);
    btn_in = '0;
    repeat (8) @(negedge clk);
    chk("t6_full", {28'd0, fifo_count}, 32'd8);
    chk("t6_ovr_pre", {31'd0, overrun}, 32'd0);
    btn_in = 5'b01000;
    repeat (2) @(negedge clk);
    btn_in = '0;
    repeat (2) @(negedge clk);
    chk("t6_ovr_first", {31'd0, overrun}, 32'd0);
    btn_in = 5'b01000;
    repeat (2) @(negedge clk);
    chk("t6_ovr_set", {31'd0, overrun}, 32'd1);
    btn_in = '0;
    repeat (3) @(negedge clk);
    event_ready = 1'b1;
    expect_ev("t6_p0", 5'b00000);
    expect_ev("t6_p1", 5'b00001);
    expect_ev("t6_p2", 5'b00010);
    expect_ev("t6_p4", 5'b00100);
    expect_ev("t6_r0", 5'b10000);
    expect_ev("t6_r1", 5'b10001);
    expect_ev("t6_r2", 5'b10010);
    expect_ev("t6_r4", 5'b10100);
    expect_ev("t6_p3", 5'b00011);
    expect_ev("t6_r3", 5'b10011);
    repeat (2) @(negedge clk);
    chk("t6_count_end", {28'd0, fifo_count}, 32'd0);
    chk("t6_valid_end", {31'd0, event_valid}, 32'd0);
    chk("t6_ovr_sticky", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("t6_ovr_clr", {31'd0, overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
